// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter
//   Round-robin arbiter and sequencer for a shared 4:1 data multiplexer.
//   One of four requesters is granted at a time. The mux select is driven
//   from the grant, and the selected data is registered onto `out` with a
//   valid flag. Grant tenure is bounded by MAX_HOLD cycles while other
//   requests are pending.
//
//   Optional feature macro: MUX_ARB_LOCK_EN
//     When it is defined, a `lock` input extends the current grant past
//     MAX_HOLD for as long as the holder keeps requesting.
//
//   Parameters:
//     WIDTH    - data width of a, b, c, d and out
//     MAX_HOLD - consecutive grant cycles before a forced rotation (1..15)
//
//   Ports:
//     clk       - clock; all state updates on the rising edge
//     rst       - synchronous active-high reset
//     req[3:0]  - request lines; bit i requests source i
//     a,b,c,d   - data for sources 0..3
//     lock      - (MUX_ARB_LOCK_EN only) keep the current grant
//     grant     - one-hot grant, or 0 when idle
//     sel       - encoded granted index; holds its last value when idle
//     out       - registered data from the selected source
//     out_valid - out holds data from a granted source
//     busy      - |grant
module mux_rr_arbiter #(
   parameter int unsigned WIDTH    = 3,
   parameter int unsigned MAX_HOLD = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       req,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   input  logic [WIDTH-1:0] d,
`ifdef MUX_ARB_LOCK_EN
   input  logic             lock,
`endif
   output logic [3:0]       grant,
   output logic [1:0]       sel,
   output logic [WIDTH-1:0] out,
   output logic             out_valid,
   output logic             busy
);

   localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t     state, state_n;
   logic [3:0] grant_n;
   logic [1:0] sel_n;
   logic [3:0] hold_cnt, hold_n;
   logic [1:0] last, last_n;
   logic       lock_hold;
   logic [3:0] cand_req;
   logic       win_found;
   logic [1:0] win_idx;

`ifdef MUX_ARB_LOCK_EN
   assign lock_hold = lock;
`else
   assign lock_hold = 1'b0;
`endif

   // First set bit of r searching cyclically from ptr+1.
   function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] ptr);
      logic       found;
      logic [1:0] idx;
      logic [1:0] cand;
      found = 1'b0;
      idx   = '0;
      for (int unsigned i = 1; i <= 4; i++) begin
         cand = ptr + 2'(i);
         if (!found && r[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
      return {found, idx};
   endfunction

   // The holder is always excluded: in IDLE grant is 0, on release its req
   // is already 0, and on expiry it must be skipped. One search covers all.
   assign cand_req = req & ~grant;
   assign {win_found, win_idx} = rr_pick(cand_req, last);

   always_comb begin
      state_n = state;
      grant_n = grant;
      sel_n   = sel;
      hold_n  = hold_cnt;
      last_n  = last;
      unique case (state)
         IDLE: begin
            if (win_found) begin
               state_n = GRANT;
               grant_n = 4'b0001 << win_idx;
               sel_n   = win_idx;
               hold_n  = 4'd1;
               last_n  = win_idx;
            end
         end
         GRANT: begin
            if (!req[sel] || (hold_cnt >= HOLD_MAX && !lock_hold)) begin
               if (win_found) begin
                  grant_n = 4'b0001 << win_idx;
                  sel_n   = win_idx;
                  hold_n  = 4'd1;
                  last_n  = win_idx;
               end else if (!req[sel]) begin
                  state_n = IDLE;
                  grant_n = '0;
                  hold_n  = '0;
               end else begin
                  hold_n  = 4'd1;
               end
            end else begin
               hold_n = (hold_cnt < HOLD_MAX) ? hold_cnt + 4'd1 : HOLD_MAX;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         grant    <= '0;
         sel      <= '0;
         hold_cnt <= '0;
         last     <= 2'd3;
      end else begin
         state    <= state_n;
         grant    <= grant_n;
         sel      <= sel_n;
         hold_cnt <= hold_n;
         last     <= last_n;
      end
   end

   logic [WIDTH-1:0] mux_data;

   always_comb begin
      mux_data = a;
      unique case (sel)
         2'd0: mux_data = a;
         2'd1: mux_data = b;
         2'd2: mux_data = c;
         2'd3: mux_data = d;
         default: mux_data = a;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out       <= '0;
         out_valid <= 1'b0;
      end else if (|grant) begin
         out       <= mux_data;
         out_valid <= 1'b1;
      end else begin
         out_valid <= 1'b0;
      end
   end

   assign busy = |grant;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter
//   Self-checking bench for mux_rr_arbiter (WIDTH=3, MAX_HOLD=4).
//   A behavioural model tracks the granted index, tenure count and
//   round-robin pointer as plain integers; the compare process checks every
//   DUT output against it on each falling edge. Directed scenarios pin the
//   model with literal expectations, then randomized traffic follows.
module tb_mux_rr_arbiter;

   localparam int W  = 3;
   localparam int MH = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic [3:0]   req;
   logic [W-1:0] a, b, c, d;
   logic         lock;
   logic [3:0]   grant;
   logic [1:0]   sel;
   logic [W-1:0] out;
   logic         out_valid;
   logic         busy;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   mux_rr_arbiter #(.WIDTH(W), .MAX_HOLD(MH)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .a         (a),
      .b         (b),
      .c         (c),
      .d         (d),
`ifdef MUX_ARB_LOCK_EN
      .lock      (lock),
`endif
      .grant     (grant),
      .sel       (sel),
      .out       (out),
      .out_valid (out_valid),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   int           m_g = -1;     // granted source, -1 when idle
   int           m_sel = 0;
   int           m_hold = 0;
   int           m_last = 3;
   logic [W-1:0] m_out = '0;
   logic         m_valid = 1'b0;
   logic [3:0]   m_req_q = '0;
   logic         m_rst_q = 1'b1;
   int           waitc[4];

   function automatic logic [W-1:0] src(input int i);
      case (i)
         0: return a;
         1: return b;
         2: return c;
         default: return d;
      endcase
   endfunction

   function automatic int pick(input logic [3:0] r, input int from);
      for (int k = 1; k <= 4; k++)
         if (r[(from + k) % 4]) return (from + k) % 4;
      return -1;
   endfunction

   always @(posedge clk) begin
      logic [3:0] r;
      int         w;
      logic       lk;
`ifdef MUX_ARB_LOCK_EN
      lk = lock;
`else
      lk = 1'b0;
`endif
      m_req_q = req;
      m_rst_q = rst;
      if (rst) begin
         m_g = -1; m_sel = 0; m_hold = 0; m_last = 3;
         m_out = '0; m_valid = 1'b0;
      end else begin
         if (m_g >= 0) begin
            m_out   = src(m_g);
            m_valid = 1'b1;
         end else begin
            m_valid = 1'b0;
         end
         if (m_g < 0) begin
            w = pick(req, m_last);
            if (w >= 0) begin m_g = w; m_sel = w; m_hold = 1; m_last = w; end
         end else if (!req[m_g]) begin
            w = pick(req, m_last);
            if (w >= 0) begin m_g = w; m_sel = w; m_hold = 1; m_last = w; end
            else m_g = -1;
         end else if (m_hold >= MH && !lk) begin
            r = req;
            r[m_g] = 1'b0;
            w = pick(r, m_last);
            if (w >= 0) begin m_g = w; m_sel = w; m_last = w; end
            m_hold = 1;
         end else begin
            m_hold = (m_hold + 1 > MH) ? MH : m_hold + 1;
         end
      end
   end

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      int wmax;
      if (chk_en) begin
         chk("grant",     grant,     (m_g < 0) ? 0 : (1 << m_g));
         chk("sel",       sel,       m_sel);
         chk("out",       out,       m_out);
         chk("out_valid", out_valid, m_valid);
         chk("busy",      busy,      m_g >= 0);
         wmax = 0;
         for (int i = 0; i < 4; i++) begin
            if (m_rst_q || lock || !m_req_q[i] || grant[i]) waitc[i] = 0;
            else waitc[i]++;
            if (waitc[i] > wmax) wmax = waitc[i];
         end
         chk("starve_bound", wmax > 3*MH, 0);
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 4; i++) waitc[i] = 0;
      a = 3'd0; b = 3'd1; c = 3'd2; d = 3'd3;
      lock = 1'b0;
      rst = 1'b1;
      req = 4'b1111;
      step();
      chk_en = 1'b1;
      step();
      chk("rst_grant", grant, 0);
      chk("rst_sel",   sel,   0);
      chk("rst_out",   out,   0);
      chk("rst_valid", out_valid, 0);
      chk("rst_busy",  busy,  0);

      // single requester
      rst = 1'b0;
      req = 4'b0100;
      step();
      chk("single_grant", grant, 4'b0100);
      chk("single_sel",   sel,   2);
      chk("single_v0",    out_valid, 0);
      step();
      chk("single_out",   out, 2);
      chk("single_v1",    out_valid, 1);
      step();
      req = 4'b0000;
      step();
      chk("single_drop_grant", grant, 0);
      chk("single_drop_v",     out_valid, 1);
      step();
      chk("single_drop_v2",    out_valid, 0);

      // full contention
      do_reset();
      req = 4'b1111;
      for (int n = 1; n <= 17; n++) begin
         step();
         chk("cont_grant", grant, 1 << (((n - 1) / 4) % 4));
         if (n >= 2) begin
            chk("cont_out",   out, ((n - 2) / 4) % 4);
            chk("cont_valid", out_valid, 1);
         end
      end
      // reset during an active grant
      rst = 1'b1;
      step();
      chk("midrst_grant", grant, 0);
      chk("midrst_sel",   sel,   0);
      chk("midrst_out",   out,   0);
      chk("midrst_valid", out_valid, 0);
      chk("midrst_busy",  busy,  0);
      rst = 1'b0;

      // early release
      req = 4'b0011;
      step();
      step();
      chk("early_g0", grant, 4'b0001);
      req = 4'b0010;
      step();
      chk("early_switch", grant, 4'b0010);
      chk("early_valid",  out_valid, 1);
      chk("early_oldout", out, 0);
      step();
      chk("early_newout", out, 1);

      // lone requester past hold
      do_reset();
      req = 4'b0001;
      for (int n = 1; n <= 10; n++) begin
         step();
         chk("lone_grant", grant, 4'b0001);
         if (n >= 2) begin
            chk("lone_out",   out, 0);
            chk("lone_valid", out_valid, 1);
         end
      end

`ifdef MUX_ARB_LOCK_EN
      do_reset();
      req  = 4'b1111;
      lock = 1'b1;
      for (int n = 1; n <= 10; n++) begin
         step();
         chk("lock_grant", grant, 4'b0001);
      end
      lock = 1'b0;
      step();
      chk("unlock_grant", grant, 4'b0010);
`endif

      // randomized traffic
      do_reset();
      req = '0;
      for (int n = 0; n < 3000; n++) begin
         for (int i = 0; i < 4; i++)
            if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
         a = W'($urandom);
         b = W'($urandom);
         c = W'($urandom);
         d = W'($urandom);
         rst = ($urandom_range(0, 299) == 0);
         step();
      end
      rst = 1'b0;
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
